// File: rtl/mc_main_control.sv
// mc_main_control: multi-cycle MIPS main control FSM (fetch, decode, execute, memory, writeback).
// Define MAIN_CTRL_MEM_WAIT_EN to add memory wait states, a wait counter and the mem_err timeout.
module mc_main_control #(
  parameter int WAIT_MAX = 255,
  parameter int STATE_W  = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         opcode,
  input  logic               mem_ready,
  output logic               PCWrite,
  output logic               PCWriteCond,
  output logic               PCWriteCondN,
  output logic               IorD,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic               RegDst,
  output logic               MemtoReg,
  output logic               RegWrite,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         ALUOp,
  output logic [1:0]         PCSrc,
  output logic               instr_done,
  output logic               illegal_op,
  output logic               mem_err,
  output logic [STATE_W-1:0] state
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    ALUWB  = 4'd7,
    BEQ    = 4'd8,
    BNE    = 4'd9,
    ADDIEX = 4'd10,
    ADDIWB = 4'd11,
    JUMP   = 4'd12
  } state_t;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       pc_write_cond_n;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
    logic       instr_done;
    logic       illegal_op;
  } ctrl_t;

  state_t cur;
  state_t nxt;
  ctrl_t  ctl;
  logic   ready;
  logic   op_legal;

  assign op_legal = opcode inside {OP_RTYPE, OP_LW, OP_SW, OP_ADDI, OP_BEQ, OP_BNE, OP_J};

`ifdef MAIN_CTRL_MEM_WAIT_EN
  localparam int CNT_W = $clog2(WAIT_MAX + 1);

  logic [CNT_W-1:0] wait_cnt;
  logic             mem_err_q;
  logic             in_wait;

  assign ready   = mem_ready;
  assign in_wait = cur inside {FETCH, MEMRD, MEMWR};
  assign mem_err = mem_err_q & ~reset;
`else
  logic [32:0] unused_cfg;

  assign ready      = 1'b1;
  assign mem_err    = 1'b0;
  assign unused_cfg = {mem_ready, 32'(WAIT_MAX)};
`endif

  // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    nxt = FETCH;
    unique case (cur)
      FETCH:  nxt = DECODE;
      DECODE: begin
        case (opcode)
          OP_RTYPE:     nxt = EXEC;
          OP_LW, OP_SW: nxt = MEMADR;
          OP_ADDI:      nxt = ADDIEX;
          OP_BEQ:       nxt = BEQ;
          OP_BNE:       nxt = BNE;
          OP_J:         nxt = JUMP;
          default:      nxt = FETCH;
        endcase
      end
      MEMADR:  nxt = (opcode == OP_LW) ? MEMRD : MEMWR;
      MEMRD:   nxt = MEMWB;
      EXEC:    nxt = ALUWB;
      ADDIEX:  nxt = ADDIWB;
      default: nxt = FETCH;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      cur <= FETCH;
`ifdef MAIN_CTRL_MEM_WAIT_EN
      wait_cnt  <= '0;
      mem_err_q <= 1'b0;
`endif
    end else begin
`ifdef MAIN_CTRL_MEM_WAIT_EN
      // A stalled memory state either keeps counting or gives up and restarts at FETCH.
      if (in_wait && !mem_ready) begin
        if (wait_cnt == CNT_W'(WAIT_MAX - 1)) begin
          cur       <= FETCH;
          wait_cnt  <= '0;
          mem_err_q <= 1'b1;
        end else begin
          wait_cnt <= wait_cnt + CNT_W'(1);
        end
      end else begin
        cur      <= nxt;
        wait_cnt <= '0;
      end
`else
      cur <= nxt;
`endif
    end
  end

  always_comb begin
    ctl = '0;
    case (cur)
      FETCH: begin
        ctl.mem_read  = 1'b1;
        ctl.alu_src_b = 2'b01;
        ctl.ir_write  = ready;
        ctl.pc_write  = ready;
      end
      DECODE: begin
        ctl.alu_src_b  = 2'b11;
        ctl.illegal_op = ~op_legal;
        ctl.instr_done = ~op_legal;
      end
      MEMADR, ADDIEX: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_src_b = 2'b10;
      end
      MEMRD: begin
        ctl.iord     = 1'b1;
        ctl.mem_read = 1'b1;
      end
      MEMWB: begin
        ctl.mem_to_reg = 1'b1;
        ctl.reg_write  = 1'b1;
        ctl.instr_done = 1'b1;
      end
      MEMWR: begin
        ctl.iord       = 1'b1;
        ctl.mem_write  = ready;
        ctl.instr_done = ready;
      end
      EXEC: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_op    = 2'b10;
      end
      ALUWB: begin
        ctl.reg_dst    = 1'b1;
        ctl.reg_write  = 1'b1;
        ctl.instr_done = 1'b1;
      end
      BEQ, BNE: begin
        ctl.alu_src_a       = 1'b1;
        ctl.alu_op          = 2'b01;
        ctl.pc_src          = 2'b01;
        ctl.pc_write_cond   = (cur == BEQ);
        ctl.pc_write_cond_n = (cur == BNE);
        ctl.instr_done      = 1'b1;
      end
      ADDIWB: begin
        ctl.reg_write  = 1'b1;
        ctl.instr_done = 1'b1;
      end
      JUMP: begin
        ctl.pc_src     = 2'b10;
        ctl.pc_write   = 1'b1;
        ctl.instr_done = 1'b1;
      end
      default: ctl = '0;
    endcase
    // Reset silences the datapath immediately, even mid-instruction.
    if (reset) ctl = '0;
  end

  assign PCWrite      = ctl.pc_write;
  assign PCWriteCond  = ctl.pc_write_cond;
  assign PCWriteCondN = ctl.pc_write_cond_n;
  assign IorD         = ctl.iord;
  assign MemRead      = ctl.mem_read;
  assign MemWrite     = ctl.mem_write;
  assign IRWrite      = ctl.ir_write;
  assign RegDst       = ctl.reg_dst;
  assign MemtoReg     = ctl.mem_to_reg;
  assign RegWrite     = ctl.reg_write;
  assign ALUSrcA      = ctl.alu_src_a;
  assign ALUSrcB      = ctl.alu_src_b;
  assign ALUOp        = ctl.alu_op;
  assign PCSrc        = ctl.pc_src;
  assign instr_done   = ctl.instr_done;
  assign illegal_op   = ctl.illegal_op;
  assign state        = STATE_W'(cur);

endmodule

// File: tb/tb_mc_main_control.sv
// tb_mc_main_control: table-driven cycle-by-cycle check of mc_main_control state and outputs,
// plus hand-written memory wait/timeout sequences when MAIN_CTRL_MEM_WAIT_EN is defined.
module tb_mc_main_control;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       pc_write_cond_n;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
    logic       instr_done;
    logic       illegal_op;
    logic       mem_err;
  } ctrl_t;

  typedef struct {
    logic       rst;
    logic [5:0] op;
    logic       chk_state;
    logic [3:0] st;
    ctrl_t      ctl;
  } vec_t;

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000, AI = 6'b001000;
  localparam logic [5:0] BQ = 6'b000100, BN = 6'b000101, JJ = 6'b000010, IL = 6'b111111;

  localparam ctrl_t C_ZERO   = '0;
  localparam ctrl_t C_FETCH  = '{mem_read:1'b1, ir_write:1'b1, alu_src_b:2'b01, pc_write:1'b1, default:'0};
  localparam ctrl_t C_DECODE = '{alu_src_b:2'b11, default:'0};
  localparam ctrl_t C_DECILL = '{alu_src_b:2'b11, illegal_op:1'b1, instr_done:1'b1, default:'0};
  localparam ctrl_t C_MEMADR = '{alu_src_a:1'b1, alu_src_b:2'b10, default:'0};
  localparam ctrl_t C_MEMRD  = '{iord:1'b1, mem_read:1'b1, default:'0};
  localparam ctrl_t C_MEMWB  = '{mem_to_reg:1'b1, reg_write:1'b1, instr_done:1'b1, default:'0};
  localparam ctrl_t C_MEMWR  = '{iord:1'b1, mem_write:1'b1, instr_done:1'b1, default:'0};
  localparam ctrl_t C_EXEC   = '{alu_src_a:1'b1, alu_op:2'b10, default:'0};
  localparam ctrl_t C_ALUWB  = '{reg_dst:1'b1, reg_write:1'b1, instr_done:1'b1, default:'0};
  localparam ctrl_t C_BEQ    = '{alu_src_a:1'b1, alu_op:2'b01, pc_src:2'b01, pc_write_cond:1'b1,
                                 instr_done:1'b1, default:'0};
  localparam ctrl_t C_BNE    = '{alu_src_a:1'b1, alu_op:2'b01, pc_src:2'b01, pc_write_cond_n:1'b1,
                                 instr_done:1'b1, default:'0};
  localparam ctrl_t C_ADDIEX = '{alu_src_a:1'b1, alu_src_b:2'b10, default:'0};
  localparam ctrl_t C_ADDIWB = '{reg_write:1'b1, instr_done:1'b1, default:'0};
  localparam ctrl_t C_JUMP   = '{pc_src:2'b10, pc_write:1'b1, instr_done:1'b1, default:'0};

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] opcode = '0;
  logic       mem_ready = 1'b1;
  logic       PCWrite, PCWriteCond, PCWriteCondN, IorD, MemRead, MemWrite, IRWrite;
  logic       RegDst, MemtoReg, RegWrite, ALUSrcA, instr_done, illegal_op, mem_err;
  logic [1:0] ALUSrcB, ALUOp, PCSrc;
  logic [3:0] state;
  ctrl_t      act;

  int checks = 0;
  int errors = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  mc_main_control #(.WAIT_MAX(4), .STATE_W(4)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .PCWriteCondN(PCWriteCondN),
    .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSrc(PCSrc), .instr_done(instr_done),
    .illegal_op(illegal_op), .mem_err(mem_err), .state(state)
  );

  assign act = {PCWrite, PCWriteCond, PCWriteCondN, IorD, MemRead, MemWrite, IRWrite,
                RegDst, MemtoReg, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSrc,
                instr_done, illegal_op, mem_err};

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic add(input logic r, input logic [5:0] op, input logic [3:0] st, input ctrl_t c,
                     input logic cs = 1'b1);
    vec_t v;
    v.rst = r; v.op = op; v.chk_state = cs; v.st = st; v.ctl = c;
    vecs.push_back(v);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset held two cycles, then released into FETCH.
    add(1, LW, 0, C_ZERO, 1'b0);
    add(1, LW, 0, C_ZERO);
    // LW: 0,1,2,3,4
    add(0, LW, 0, C_FETCH); add(0, LW, 1, C_DECODE); add(0, LW, 2, C_MEMADR);
    add(0, LW, 3, C_MEMRD); add(0, LW, 4, C_MEMWB);
    // R-type then SW back-to-back
    add(0, RT, 0, C_FETCH); add(0, RT, 1, C_DECODE); add(0, RT, 6, C_EXEC); add(0, RT, 7, C_ALUWB);
    add(0, SW, 0, C_FETCH); add(0, SW, 1, C_DECODE); add(0, SW, 2, C_MEMADR); add(0, SW, 5, C_MEMWR);
    // Branches, jump, ADDI
    add(0, BN, 0, C_FETCH); add(0, BN, 1, C_DECODE); add(0, BN, 9, C_BNE);
    add(0, JJ, 0, C_FETCH); add(0, JJ, 1, C_DECODE); add(0, JJ, 12, C_JUMP);
    add(0, BQ, 0, C_FETCH); add(0, BQ, 1, C_DECODE); add(0, BQ, 8, C_BEQ);
    add(0, AI, 0, C_FETCH); add(0, AI, 1, C_DECODE); add(0, AI, 10, C_ADDIEX); add(0, AI, 11, C_ADDIWB);
    // Illegal opcode: pulse in DECODE, back to FETCH
    add(0, IL, 0, C_FETCH); add(0, IL, 1, C_DECILL);
    // Reset asserted in MEMRD silences outputs, then restarts at FETCH
    add(0, LW, 0, C_FETCH); add(0, LW, 1, C_DECODE); add(0, LW, 2, C_MEMADR);
    add(1, LW, 3, C_ZERO);  add(0, LW, 0, C_FETCH);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      reset     = vecs[i].rst;
      opcode    = vecs[i].op;
      mem_ready = 1'b1;
      #1;
      if (vecs[i].chk_state) check($sformatf("vec%0d state", i), 32'(state), 32'(vecs[i].st));
      check($sformatf("vec%0d outputs", i), 32'(act), 32'(vecs[i].ctl));
    end

`ifdef MAIN_CTRL_MEM_WAIT_EN
    // FETCH stalls two cycles; IRWrite/PCWrite fire once when ready arrives.
    @(negedge clk);
    reset = 1'b1; mem_ready = 1'b0; opcode = SW;
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 2; c++) begin
      #1;
      check($sformatf("wait fetch%0d state", c), 32'(state), 32'd0);
      check($sformatf("wait fetch%0d IRWrite", c), 32'(IRWrite), 32'd0);
      check($sformatf("wait fetch%0d PCWrite", c), 32'(PCWrite), 32'd0);
      check($sformatf("wait fetch%0d MemRead", c), 32'(MemRead), 32'd1);
      @(negedge clk);
    end
    mem_ready = 1'b1;
    #1;
    check("ready fetch state", 32'(state), 32'd0);
    check("ready fetch IRWrite", 32'(IRWrite), 32'd1);
    check("ready fetch PCWrite", 32'(PCWrite), 32'd1);
    @(negedge clk); #1;
    check("after fetch state", 32'(state), 32'd1);
    check("after fetch IRWrite", 32'(IRWrite), 32'd0);
    @(negedge clk); #1;
    check("sw memadr state", 32'(state), 32'd2);
    // MEMWR stuck: four cycles of no MemWrite, then timeout to FETCH with mem_err set.
    @(negedge clk);
    mem_ready = 1'b0;
    #1;
    for (int c = 0; c < 4; c++) begin
      check($sformatf("memwr wait%0d state", c), 32'(state), 32'd5);
      check($sformatf("memwr wait%0d MemWrite", c), 32'(MemWrite), 32'd0);
      check($sformatf("memwr wait%0d instr_done", c), 32'(instr_done), 32'd0);
      check($sformatf("memwr wait%0d mem_err", c), 32'(mem_err), 32'd0);
      @(negedge clk); #1;
    end
    check("timeout state", 32'(state), 32'd0);
    check("timeout mem_err", 32'(mem_err), 32'd1);
    @(negedge clk); #1;
    check("mem_err sticky", 32'(mem_err), 32'd1);
    check("mem_err sticky IRWrite", 32'(IRWrite), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("mem_err during reset", 32'(mem_err), 32'd0);
    @(negedge clk);
    reset = 1'b0; mem_ready = 1'b1;
    #1;
    check("mem_err after reset", 32'(mem_err), 32'd0);
    check("state after reset", 32'(state), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
